// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter. The shift amount arrives as base-3 digits; stage k
// applies digit_k * 3^k, so a request crosses DIGITS register stages. Each
// stage has its own valid bit. A stage moves forward whenever the stage after it
// can take its entry, so empty stages are filled without waiting.
module pipelined_shifter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [1:0]            in_op,
  input  logic [2*DIGITS-1:0]   in_digits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  output logic                  busy
);

  localparam int DW = 2 * DIGITS;
  // The largest amount one stage applies is 2*3^3 = 54, so 8 bits hold it.
  localparam int AW = 8;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic [DIGITS-1:0] valid_reg;
  logic [DIGITS-1:0] err_reg;
  logic [WIDTH-1:0]  data_reg   [DIGITS];
  logic [1:0]        op_reg     [DIGITS];
  logic [DW-1:0]     digits_reg [DIGITS];

  logic [WIDTH-1:0]  data_next   [DIGITS];
  logic [DW-1:0]     digits_next [DIGITS];
  logic [DIGITS-1:0] adv;
  logic              in_err;

  // Detect an illegal digit (value 3) anywhere in the incoming shift amount.
  always_comb begin
    in_err = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (in_digits[2*k +: 2] == 2'd3) in_err = 1'b1;
    end
  end

  // Compute the advance chain from the output end back to stage 0.
  always_comb begin
    adv = '0;
    adv[DIGITS-1] = !valid_reg[DIGITS-1] || out_ready;
    for (int k = DIGITS - 2; k >= 0; k--) begin
      adv[k] = !valid_reg[k] || adv[k+1];
    end
  end

  assign in_ready  = !rst && adv[0];
  assign out_valid = valid_reg[DIGITS-1];
  assign out_data  = data_reg[DIGITS-1];
  assign out_err   = err_reg[DIGITS-1];
  assign busy      = |valid_reg;

  // Per-stage shift logic. The low digit of the remaining field belongs to this stage.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_stage
      localparam int POW = 3 ** gi;
      logic [WIDTH-1:0] src;
      logic [1:0]       op;
      logic [DW-1:0]    dig;
      logic [AW-1:0]    amt;
      logic [AW-1:0]    rot;
      logic [WIDTH-1:0] shifted;

      if (gi == 0) begin : g_head
        // A request with an illegal digit enters as zero, so it comes out as zero.
        assign src = in_err ? '0 : in_data;
        assign op  = in_op;
        assign dig = in_digits;
      end else begin : g_body
        assign src = data_reg[gi-1];
        assign op  = op_reg[gi-1];
        assign dig = digits_reg[gi-1];
      end

      assign amt = AW'(dig[1:0]) * AW'(POW);
      assign rot = amt % AW'(WIDTH);

      // Shift by this stage's share. Amounts of WIDTH or more saturate; a rotate wraps.
      always_comb begin
        shifted = src;
        case (op)
          OP_SLL:  shifted = src << amt;
          OP_SRL:  shifted = src >> amt;
          OP_SRA:  shifted = $unsigned($signed(src) >>> amt);
          default: shifted = (src << rot) | (src >> (AW'(WIDTH) - rot));
        endcase
      end

      assign data_next[gi]   = shifted;
      assign digits_next[gi] = dig >> 2;
    end
  endgenerate

  // Stage registers. Each stage loads from upstream whenever it advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      err_reg   <= '0;
      for (int k = 0; k < DIGITS; k++) begin
        data_reg[k]   <= '0;
        op_reg[k]     <= '0;
        digits_reg[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        valid_reg[0]  <= in_valid;
        err_reg[0]    <= in_err;
        op_reg[0]     <= in_op;
        data_reg[0]   <= data_next[0];
        digits_reg[0] <= digits_next[0];
      end
      for (int k = 1; k < DIGITS; k++) begin
        if (adv[k]) begin
          valid_reg[k]  <= valid_reg[k-1];
          err_reg[k]    <= err_reg[k-1];
          op_reg[k]     <= op_reg[k-1];
          data_reg[k]   <= data_next[k];
          digits_reg[k] <= digits_next[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter (WIDTH=16, DIGITS=3). Directed steps run in one
// initial block. A scoreboard queue holds the expected {err,data} for each
// request, and the output monitor pops one entry for each result it takes.
module tb_pipelined_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_op = '0;
  logic [5:0]  in_digits = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_err;
  logic        busy;

  int tests = 0;
  int fails = 0;
  bit rand_bp = 1'b0;
  logic [16:0] sb_q[$];

  pipelined_shifter #(.WIDTH(16), .DIGITS(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_digits(in_digits),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: apply the shift one bit at a time, S times.
  function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] d,
                                        input logic [5:0] dg);
    int s;
    logic [15:0] r;
    if (dg[1:0] == 2'd3 || dg[3:2] == 2'd3 || dg[5:4] == 2'd3) return {1'b1, 16'h0000};
    s = int'(dg[1:0]) + 3 * int'(dg[3:2]) + 9 * int'(dg[5:4]);
    r = d;
    for (int i = 0; i < s; i++) begin
      case (op)
        2'b00:   r = {r[14:0], 1'b0};
        2'b01:   r = {1'b0, r[15:1]};
        2'b10:   r = {r[15], r[15:1]};
        default: r = {r[14:0], r[15]};
      endcase
    end
    return {1'b0, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait until it is accepted. Push its expected result at acceptance.
  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [5:0] dg,
                      input logic [16:0] exp);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_data = d; in_digits = dg;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(exp);
        step();
        break;
      end
      step();
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [1:0] op, input logic [15:0] d, input logic [5:0] dg);
    send(op, d, dg, model(op, d, dg));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || busy) && n < 100) begin
      step();
      n++;
    end
    chk("drain_queue", 32'(sb_q.size()), 32'd0);
  endtask

  // Check a request that was just accepted: the result appears exactly 3 cycles later.
  task automatic lat_check(input string tag, input logic [15:0] exp);
    chk({tag, "_lat0"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
  endtask

  // Output monitor: take each result and compare it with the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) chk("sb_result", 32'({out_err, out_data}), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    logic [16:0] a_exp;

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // SLL 0x0001 by 14: exactly 3-cycle latency
    send(2'b00, 16'h0001, {2'd1, 2'd1, 2'd2}, {1'b0, 16'h4000});
    lat_check("sll14", 16'h4000);
    chk("sll14_err", 32'(out_err), 32'd0);
    drain();

    // SRA and SRL of 0x8000 by 15; ROL by 20; SLL by 26 (saturates)
    send(2'b10, 16'h8000, {2'd1, 2'd2, 2'd0}, {1'b0, 16'hFFFF});
    send(2'b01, 16'h8000, {2'd1, 2'd2, 2'd0}, {1'b0, 16'h0001});
    send(2'b11, 16'h8001, {2'd2, 2'd0, 2'd2}, {1'b0, 16'h0018});
    send(2'b00, 16'hFFFF, {2'd2, 2'd2, 2'd2}, {1'b0, 16'h0000});
    // S=0 passes through unchanged
    send(2'b10, 16'hA5C3, 6'd0, {1'b0, 16'hA5C3});
    send(2'b11, 16'h1234, 6'd0, {1'b0, 16'h1234});
    // Illegal digit, followed at once by a legal request
    send(2'b00, 16'hBEEF, {2'd0, 2'd3, 2'd1}, {1'b1, 16'h0000});
    send(2'b01, 16'hF0F0, {2'd0, 2'd1, 2'd1}, {1'b0, 16'h0F0F});
    drain();

    // Backpressure: only 3 requests fit; the head result holds steady
    out_ready = 1'b0;
    a_exp = model(2'b11, 16'h00F1, 6'b000101);
    send(2'b11, 16'h00F1, 6'b000101, a_exp);
    sendm(2'b00, 16'h0F0F, 6'b000110);
    sendm(2'b10, 16'h9000, 6'b010000);
    in_valid = 1'b1; in_op = 2'b01; in_data = 16'hCAFE; in_digits = 6'b000010;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'({out_err, out_data}), 32'(a_exp));
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    sendm(2'b01, 16'hCAFE, 6'b000010);
    sendm(2'b11, 16'h8000, 6'b100001);
    drain();

    // Random requests under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sendm(2'($urandom_range(0, 3)), 16'($urandom), 6'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    rand_bp = 1'b0;
    drain();

    // Reset with two entries in flight
    sendm(2'b00, 16'h0003, 6'b000001);
    sendm(2'b01, 16'h0300, 6'b000010);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    sb_q.delete();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    send(2'b11, 16'h4001, 6'b000001, {1'b0, 16'h8002});
    lat_check("post_rst", 16'h8002);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 The parameter WIDTH, default 16, SHALL set the data width in bits (legal range 4..64).
REQ-002 The parameter DIGITS, default 3, SHALL set the number of base-3 shift digits and the number of pipeline stages (legal range 1..4).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that a request is present on the in_* bus.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts the request this cycle.
REQ-007 in_data  input  WIDTH  SHALL carry the operand.
REQ-008 in_op  input  2  SHALL select the operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left).
REQ-009 in_digits  input  2*DIGITS  SHALL carry the shift amount; bits [2k+1:2k] are digit k with weight 3^k.
REQ-010 out_valid  output  1  SHALL indicate that a result is present on out_data and out_err.
REQ-011 out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-012 out_data  output  WIDTH  SHALL carry the shifted result.
REQ-013 out_err  output  1  SHALL flag an illegal digit in the request.
REQ-014 busy  output  1  SHALL be high when any pipeline stage holds a valid entry.

Function
REQ-015 A transfer SHALL occur on the in side when in_valid && in_ready, and on the out side when out_valid && out_ready.
REQ-016 Pipeline structure: DIGITS register stages.
- Stage k SHALL apply shift digit_k*3^k using the operation held in that entry.
- Each stage SHALL carry valid, data, op, the remaining digits and err.
REQ-017 Latency: with no stall, a request accepted in cycle t SHALL appear with out_valid=1 in cycle t+DIGITS.
REQ-018 Throughput: with out_ready held high, the block SHALL accept one request per cycle.
REQ-019 Stall rule: stage k SHALL advance when it is empty or stage k+1 advances; the last stage SHALL advance when it is empty or out_ready=1.
REQ-020 in_ready SHALL equal stage-0-empty OR stage-0-advancing, SHALL be combinational, and SHALL be 0 while rst=1.
REQ-021 Held outputs: while out_valid=1 and out_ready=0, out_data and out_err SHALL hold stable.
REQ-022 Ordering: results SHALL emerge in acceptance order, with none dropped or duplicated; capacity is DIGITS entries.
REQ-023 Shift amount S SHALL equal sum(digit_k*3^k), giving a range of 0..3^DIGITS-1.
REQ-024 SLL and SRL SHALL fill vacated bits with 0.
REQ-025 SRA SHALL fill vacated bits with in_data[WIDTH-1].
REQ-026 S>=WIDTH:
- SLL and SRL SHALL return all zeros.
- SRA SHALL return all copies of the sign bit.
- ROL SHALL rotate by S mod WIDTH.
REQ-027 Shift amount S=0 SHALL pass in_data unchanged for every operation.
REQ-028 Illegal digit: if any digit equals 3, the entry SHALL set err=1 at acceptance, produce out_data=0 and out_err=1, and occupy a normal pipeline slot.
REQ-029 Bubbles: empty stages SHALL NOT produce out_valid.

Reset
REQ-030 While rst=1, the block SHALL hold out_valid=0, busy=0, out_data=0, out_err=0, in_ready=0 and all stage valid bits at 0.
REQ-031 Reset mid-operation SHALL discard all in-flight entries, with no result emitted afterwards.
REQ-032 In the first cycle after rst deasserts, in_ready SHALL be 1.

Verification (WIDTH=16, DIGITS=3, digits listed d0,d1,d2)
REQ-033 SLL 0x0001 with digits 2,1,1 (S=14), out_ready=1 -> out_data=0x4000, out_err=0, exactly 3 cycles after acceptance.
REQ-034 0x8000 with digits 0,2,1 (S=15) -> SRA gives 0xFFFF; SRL gives 0x0001.
REQ-035 ROL 0x8001 with digits 2,0,2 (S=20) -> 0x0018; SLL 0xFFFF with digits 2,2,2 (S=26) -> 0x0000.
REQ-036 Digits 1,3,0 -> out_err=1, out_data=0; a legal request sent in the next cycle -> correct result in the next cycle slot.
REQ-037 Backpressure: out_ready=0 and 5 back-to-back requests (A..E) -> in_ready falls after 3 are accepted; out_data stays stable; raising out_ready -> A..E delivered in order with none lost.
REQ-038 rst pulsed with 2 entries in flight -> out_valid=0 and busy=0 immediately; no stale output; the next request completes with 3-cycle latency.
